// File: rtl/sdram_block_responder.sv
// Memory-side block-refill responder: captures a block read request and streams one cache block of words.
// Latency: first word is registered LATENCY edges after the capture edge, then one word per cycle for BLOCK_WORDS cycles.
// Backpressure: none; a started burst always completes. The requester must take every word while memDataReady is high.
//
// Optional build macro SDRAM_CRITICAL_WORD_FIRST_EN: when defined, the burst starts at the requested
// word and wraps within the block. When undefined, the burst always runs in order 0..BLOCK_WORDS-1.
module sdram_block_responder #(
    parameter int MEM_WORDS   = 4096,
    parameter int BLOCK_WORDS = 4,
    parameter int LATENCY     = 4,
    parameter int WORD_SIZE   = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           memReadRequest,
    input  logic [31:0]                    memReadAddress,
    output logic [WORD_SIZE-1:0]           memDataOut,
    output logic                           memDataReady,
    output logic [$clog2(BLOCK_WORDS)-1:0] memBlockIndex,
    output logic                           busy,
    input  logic                           wrEn,
    input  logic [31:0]                    wrAddr,
    input  logic [WORD_SIZE-1:0]           wrData
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int IW = $clog2(BLOCK_WORDS);
    localparam int LW = $clog2(LATENCY + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [WORD_SIZE-1:0] mem [MEM_WORDS];

    logic [1:0]           state_q, state_d;
    logic [LW-1:0]        lat_q, lat_d;
    logic [IW-1:0]        k_q, k_d;
    logic [AW-IW-1:0]     blk_q, blk_d;
    logic [IW-1:0]        off_q, off_d;
    logic                 rdy_d;
    logic [IW-1:0]        idx_d;
    logic [AW-1:0]        rd_addr;
    logic [AW-1:0]        req_word;
    logic [AW-1:0]        wr_word;

    logic [WORD_SIZE-1:0] dout_q;
    logic                 rdy_q;
    logic [IW-1:0]        idx_q;
    logic                 busy_q;

    // Upper address bits and byte-lane bits are deliberately ignored: addresses wrap modulo MEM_WORDS.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{memReadAddress[31:AW+2], memReadAddress[1:0],
                                wrAddr[31:AW+2], wrAddr[1:0]};

    assign req_word = memReadAddress[AW+1:2];
    assign wr_word  = wrAddr[AW+1:2];
    assign rd_addr  = {blk_q, idx_d};

    // Position within the block of the word emitted at burst step k.
    function automatic logic [IW-1:0] burst_idx(input logic [IW-1:0] off, input logic [IW-1:0] k);
`ifdef SDRAM_CRITICAL_WORD_FIRST_EN
        return off + k;
`else
        return k + (off & '0);
`endif
    endfunction

    // Next-state logic: capture, latency countdown with abort, burst sequencing, single gap cycle.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        k_d     = k_q;
        blk_d   = blk_q;
        off_d   = off_q;
        rdy_d   = 1'b0;
        idx_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (memReadRequest) begin
                    blk_d   = req_word[AW-1:IW];
                    off_d   = req_word[IW-1:0];
                    lat_d   = LW'(LATENCY - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // With LATENCY=1 the capture already commits to the burst, so there is nothing to abort.
                if (!memReadRequest && (LATENCY > 1)) begin
                    state_d = S_IDLE;
                    lat_d   = '0;
                end else if (lat_q == '0) begin
                    state_d = S_BURST;
                    k_d     = '0;
                    rdy_d   = 1'b1;
                    idx_d   = burst_idx(off_q, '0);
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            S_BURST: begin
                if (k_q == IW'(BLOCK_WORDS - 1)) begin
                    state_d = S_GAP;
                    k_d     = '0;
                end else begin
                    k_d   = k_q + IW'(1);
                    rdy_d = 1'b1;
                    idx_d = burst_idx(off_q, k_q + IW'(1));
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state and registered outputs; the output word is read from RAM on the edge it becomes visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            k_q     <= '0;
            blk_q   <= '0;
            off_q   <= '0;
            dout_q  <= '0;
            rdy_q   <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            k_q     <= k_d;
            blk_q   <= blk_d;
            off_q   <= off_d;
            dout_q  <= rdy_d ? mem[rd_addr] : '0;
            rdy_q   <= rdy_d;
            idx_q   <= rdy_d ? idx_d : '0;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    // Preload port; a same-edge read of the written word sees the old contents. RAM is not reset.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wr_word] <= wrData;
        end
    end

    assign memDataOut    = dout_q;
    assign memDataReady  = rdy_q;
    assign memBlockIndex = idx_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_sdram_block_responder.sv
// Bench for sdram_block_responder: directed block reads with a timestamped scoreboard.
// Stimulus pushes expected (data, index, cycle) entries; a negedge monitor pops and compares on memDataReady.
// Control-state checks (reset values, busy, abort) are made directly by the stimulus process.
module tb_sdram_block_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        memReadRequest;
    logic [31:0] memReadAddress;
    logic [31:0] memDataOut;
    logic        memDataReady;
    logic [1:0]  memBlockIndex;
    logic        busy;
    logic        wrEn;
    logic [31:0] wrAddr;
    logic [31:0] wrData;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  i;
        int          c;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;

    localparam logic [31:0] A0 = 32'hA0A0_0000;
    localparam logic [31:0] A1 = 32'hA1A1_1111;
    localparam logic [31:0] A2 = 32'hA2A2_2222;
    localparam logic [31:0] A3 = 32'hA3A3_3333;

    sdram_block_responder dut (
        .clk            (clk),
        .reset          (reset),
        .memReadRequest (memReadRequest),
        .memReadAddress (memReadAddress),
        .memDataOut     (memDataOut),
        .memDataReady   (memDataReady),
        .memBlockIndex  (memBlockIndex),
        .busy           (busy),
        .wrEn           (wrEn),
        .wrAddr         (wrAddr),
        .wrData         (wrData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000 time units");
        $fatal(1, "timeout");
    end

    // Monitor: every presented word must match the head of the scoreboard, including its cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (memDataReady === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word cyc=%0d got data=%h idx=%0d, required no word", cyc, memDataOut, memBlockIndex);
                end else begin
                    e = sb.pop_front();
                    if (memDataOut !== e.d || memBlockIndex !== e.i || cyc != e.c) begin
                        failures++;
                        $display("FAIL burst_word got data=%h idx=%0d cyc=%0d, required data=%h idx=%0d cyc=%0d",
                                 memDataOut, memBlockIndex, cyc, e.d, e.i, e.c);
                    end
                end
            end else begin
                checks++;
                if (memDataReady !== 1'b0 || memDataOut !== 32'h0) begin
                    failures++;
                    $display("FAIL idle_output cyc=%0d got ready=%b data=%h, required ready=0 data=0", cyc, memDataReady, memDataOut);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d got %h, required %h", name, cyc, act, req);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [1:0] i, input int c);
        exp_t x;
        x.d = d; x.i = i; x.c = c;
        sb.push_back(x);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        wrEn = 1'b1; wrAddr = a; wrData = d;
        tick();
        wrEn = 1'b0;
    endtask

    // Full block read; optionally writes (wa, wd) on the edge that loads burst word k=1.
    task automatic read_block(input logic [31:0] addr,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input logic [1:0] i0, input logic [1:0] i1,
                              input logic [1:0] i2, input logic [1:0] i3,
                              input bit do_wr, input logic [31:0] wa, input logic [31:0] wd);
        int e0;
        e0 = cyc + 1;
        push(d0, i0, e0 + 4);
        push(d1, i1, e0 + 5);
        push(d2, i2, e0 + 6);
        push(d3, i3, e0 + 7);
        memReadRequest = 1'b1;
        memReadAddress = addr;
        tick();
        chk("busy_in_wait", {31'b0, busy}, 32'd1);
        repeat (4) tick();
        memReadRequest = 1'b0;
        if (do_wr) begin
            wrEn = 1'b1; wrAddr = wa; wrData = wd;
        end
        tick();
        wrEn = 1'b0;
        repeat (3) tick();
        chk("busy_in_gap", {31'b0, busy}, 32'd1);
        chk("ready_in_gap", {31'b0, memDataReady}, 32'd0);
        tick();
        chk("busy_after_gap", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int e0;
        reset = 1'b1; memReadRequest = 1'b0; memReadAddress = '0;
        wrEn = 1'b0; wrAddr = '0; wrData = '0;
        repeat (3) tick();
        chk("reset_ready", {31'b0, memDataReady}, 32'd0);
        chk("reset_data", memDataOut, 32'd0);
        chk("reset_index", {30'b0, memBlockIndex}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        tick();

        preload(32'h100, A0);
        preload(32'h104, A1);
        preload(32'h108, A2);
        preload(32'h10C, A3);
        tick();

        // Aligned request.
        read_block(32'h100, A0, A1, A2, A3, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 32'h0, 32'h0);
        tick();

        // Request for the third word of the block.
`ifdef SDRAM_CRITICAL_WORD_FIRST_EN
        read_block(32'h108, A2, A3, A0, A1, 2'd2, 2'd3, 2'd0, 2'd1, 1'b0, 32'h0, 32'h0);
`else
        read_block(32'h108, A0, A1, A2, A3, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 32'h0, 32'h0);
`endif
        tick();

        // Abort after two cycles in WAIT, then a normal request two cycles later.
        memReadRequest = 1'b1; memReadAddress = 32'h100;
        tick();
        tick();
        memReadRequest = 1'b0;
        tick();
        chk("busy_after_abort", {31'b0, busy}, 32'd0);
        repeat (2) tick();
        read_block(32'h100, A0, A1, A2, A3, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 32'h0, 32'h0);
        tick();

        // Write word 0x41 on the edge it is streamed: old data now, new data next read.
        read_block(32'h100, A0, A1, A2, A3, 2'd0, 2'd1, 2'd2, 2'd3, 1'b1, 32'h104, 32'hDEAD);
        tick();
        read_block(32'h100, A0, 32'hDEAD, A2, A3, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 32'h0, 32'h0);
        preload(32'h104, A1);
        tick();

        // Reset during burst step k=1.
        e0 = cyc + 1;
        push(A0, 2'd0, e0 + 4);
        push(A1, 2'd1, e0 + 5);
        memReadRequest = 1'b1; memReadAddress = 32'h100;
        tick();
        repeat (4) tick();
        memReadRequest = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("midburst_reset_ready", {31'b0, memDataReady}, 32'd0);
        chk("midburst_reset_data", memDataOut, 32'd0);
        chk("midburst_reset_index", {30'b0, memBlockIndex}, 32'd0);
        chk("midburst_reset_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        tick();
        read_block(32'h100, A0, A1, A2, A3, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 32'h0, 32'h0);
        tick();

        // Out-of-range address wraps to word 0x40.
        read_block(32'h4100, A0, A1, A2, A3, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 32'h0, 32'h0);
        repeat (3) tick();

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
